// File: rtl/vga_rect_fill.sv
// Rectangle fill sequencer for the VGA adapter plot port.
// It takes one start command and emits one plot strobe per clock, in raster order.
// The rectangle is clipped to the screen. The hold input stalls the sequence without
// skipping or repeating a pixel.
module vga_rect_fill #(
   parameter string       RESOLUTION   = "320x240",
   parameter int unsigned COLOUR_WIDTH = 3,
   localparam bit          HiRes        = (RESOLUTION == "320x240"),
   localparam int unsigned XW           = HiRes ? 9 : 8,
   localparam int unsigned YW           = HiRes ? 8 : 7,
   localparam int unsigned XRES         = HiRes ? 320 : 160,
   localparam int unsigned YRES         = HiRes ? 240 : 120
) (
   input  logic                    clock,
   input  logic                    resetn,
   input  logic                    start,
   input  logic [XW-1:0]           x0,
   input  logic [YW-1:0]           y0,
   input  logic [XW-1:0]           w,
   input  logic [YW-1:0]           h,
   input  logic [COLOUR_WIDTH-1:0] colour_in,
   input  logic                    hold,
   output logic [XW-1:0]           x,
   output logic [YW-1:0]           y,
   output logic [COLOUR_WIDTH-1:0] colour,
   output logic                    plot,
   output logic                    busy,
   output logic                    done
);

   typedef enum logic [1:0] {StIdle, StFill, StDone} state_e;

   localparam logic [XW:0]   XResW = XRES[XW:0];
   localparam logic [YW:0]   YResW = YRES[YW:0];
   localparam logic [XW-1:0] XInc  = {{(XW-1){1'b0}}, 1'b1};
   localparam logic [YW-1:0] YInc  = {{(YW-1){1'b0}}, 1'b1};

   state_e                  state_q, state_d;
   logic [XW-1:0]           x0_q, x0_d, xend_q, xend_d, x_q, x_d;
   logic [YW-1:0]           yend_q, yend_d, y_q, y_d;
   logic [COLOUR_WIDTH-1:0] colour_q, colour_d;
   logic                    plot_q, plot_d, busy_q, busy_d, done_q, done_d;

   // Clipping works one bit wider than the operands, so XRES - x0 can never wrap.
   logic [XW:0]   x0_ext, w_ext, x_room, we;
   logic [YW:0]   y0_ext, h_ext, y_room, he;
   logic [XW-1:0] xend;
   logic [YW-1:0] yend;
   logic          area_zero, last_px;

   assign x0_ext = {1'b0, x0};
   assign w_ext  = {1'b0, w};
   assign x_room = XResW - x0_ext;
   assign we     = (x0_ext >= XResW) ? '0 : ((w_ext < x_room) ? w_ext : x_room);
   assign y0_ext = {1'b0, y0};
   assign h_ext  = {1'b0, h};
   assign y_room = YResW - y0_ext;
   assign he     = (y0_ext >= YResW) ? '0 : ((h_ext < y_room) ? h_ext : y_room);

   // A non-zero clipped extent is at most XRES (or YRES), so it fits in XW (or YW) bits.
   assign xend      = x0 + we[XW-1:0] - XInc;
   assign yend      = y0 + he[YW-1:0] - YInc;
   assign area_zero = (we == '0) || (he == '0);
   assign last_px   = (x_q == xend_q) && (y_q == yend_q);

   // State and registered outputs.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q  <= StIdle;
         x0_q     <= '0;
         xend_q   <= '0;
         yend_q   <= '0;
         x_q      <= '0;
         y_q      <= '0;
         colour_q <= '0;
         plot_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         x0_q     <= x0_d;
         xend_q   <= xend_d;
         yend_q   <= yend_d;
         x_q      <= x_d;
         y_q      <= y_d;
         colour_q <= colour_d;
         plot_q   <= plot_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   // Next state. The fill ends once the last pixel has actually been plotted.
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: if (start) state_d = area_zero ? StDone : StFill;
         StFill: if (plot_q && last_px) state_d = StDone;
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Next output values. (x_q, y_q) is the pixel on offer. It advances only after a cycle
   // in which it was plotted. hold only masks the plot strobe for the following cycle.
   always_comb begin
      x0_d     = x0_q;
      xend_d   = xend_q;
      yend_d   = yend_q;
      x_d      = x_q;
      y_d      = y_q;
      colour_d = colour_q;
      plot_d   = 1'b0;
      case (state_q)
         StIdle: begin
            if (start) begin
               x0_d   = x0;
               xend_d = xend;
               yend_d = yend;
               if (!area_zero) begin
                  x_d      = x0;
                  y_d      = y0;
                  colour_d = colour_in;
                  plot_d   = 1'b1;
               end
            end
         end
         StFill: begin
            if (plot_q) begin
               if (!last_px) begin
                  plot_d = !hold;
                  if (x_q != xend_q) begin
                     x_d = x_q + XInc;
                  end else begin
                     x_d = x0_q;
                     y_d = y_q + YInc;
                  end
               end
            end else begin
               plot_d = !hold;
            end
         end
         default: ;
      endcase
      busy_d = (state_d == StFill);
      done_d = (state_d == StDone);
   end

   assign x      = x_q;
   assign y      = y_q;
   assign colour = colour_q;
   assign plot   = plot_q;
   assign busy   = busy_q;
   assign done   = done_q;

endmodule

// File: doc/vga_rect_fill.md
Name: vga_rect_fill

Overview:
- Sequencer that drives the VGA adapter plot port (x, y, colour, plot) to fill an axis-aligned rectangle in raster order, one pixel per clock.
- Sits between game/drawing logic and the adapter. Used for screen clears, sprite backgrounds and blocks.
- Converts a single start command into a stream of plot strobes. The adapter's address translator turns each (x, y) into a video memory address.

Parameters:
- RESOLUTION, "320x240", screen size; the only other legal value is "160x120". Sets XW, YW, XRES and YRES.
- COLOUR_WIDTH, 3, width of the colour bus.
- Derived values, not overridable:
  - XW = 9 (320x240) or 8 (160x120).
  - YW = 8 or 7.
  - XRES = 320 or 160.
  - YRES = 240 or 120.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- resetn  in  1  reset.
- start  in  1  command strobe, sampled only in IDLE.
- x0  in  XW  top-left x.
- y0  in  YW  top-left y.
- w  in  XW  width in pixels.
- h  in  YW  height in pixels.
- colour_in  in  COLOUR_WIDTH  fill colour.
- hold  in  1  stall request from the plot-port owner; freezes the sequence.
- x  out  XW  pixel x to the adapter.
- y  out  YW  pixel y to the adapter.
- colour  out  COLOUR_WIDTH  pixel colour to the adapter.
- plot  out  1  write enable to the adapter.
- busy  out  1  high from command acceptance until done.
- done  out  1  one-cycle completion pulse.

Interface rule (already decided): one clock, "clock"; reset is asynchronous and active-low, "resetn". All outputs are registered.

Behaviour:
- Reset (resetn=0, any time, including mid-fill):
  - State goes to IDLE immediately.
  - x, y, colour, plot, busy and done all clear to 0.
  - No pending command survives reset.
- States: IDLE, FILL, DONE.
- IDLE:
  - plot=0, busy=0, done=0; x, y and colour hold their last values.
  - On the edge where start=1, latch x0, y0 and colour_in, and compute clipped extents:
    - we = 0 if x0>=XRES, else min(w, XRES-x0).
    - he = 0 if y0>=YRES, else min(h, YRES-y0).
    - Computations are unsigned, one bit wider than the operands; no wrap.
  - If we==0 or he==0, go to DONE.
  - Otherwise go to FILL, with registered outputs x=x0, y=y0, colour=latched colour, plot=1, busy=1.
- Latency: the first plot is visible in the cycle immediately after the start edge.
- FILL, per edge with hold=0:
  - If x < x0+we-1: x increments.
  - Else if y < y0+he-1: x returns to x0 and y increments.
  - Else, on the last pixel: go to DONE with plot=0.
  - plot=1 on every non-final advance.
- FILL, per edge with hold=1:
  - x, y and counters freeze; plot is driven 0 for as long as hold stays high.
  - When hold drops, the same (x, y) is re-presented with plot=1. No pixel is skipped or duplicated.
- Pixel count: exactly we*he plot-high cycles per command, in raster order (x fastest).
- DONE (one cycle):
  - done=1 and busy=0, both registered.
  - Next edge goes to IDLE.
  - start is ignored while in DONE.
- start while busy (FILL or DONE) is ignored; the latched command is unaffected.
- colour_in, x0, y0, w and h may change after acceptance without effect.
- Full-screen fill (x0=0, y0=0, w=XRES, h=YRES) yields XRES*YRES plots with no intermediate idle cycles when hold=0.
- Oversized w or h (max field value) is clipped by the rule above.

Test Plan:
- Basic fill at 320x240: x0=3, y0=5, w=2, h=2, colour=3'b101, start 1 cycle.
  - Required: plots at (3,5), (4,5), (3,6), (4,6) on 4 consecutive cycles starting the cycle after start.
  - Then done=1 for exactly 1 cycle; busy high for exactly the 4 plot cycles.
- Clipping: x0=318, y0=238, w=4, h=4.
  - Required: exactly 4 plots, at (318,238), (319,238), (318,239), (319,239).
  - No plot with x>=320 or y>=240; then done.
- Zero and off-screen areas: w=0, h=7 -> no plot, done=1 in the cycle after start.
  - x0=320 -> same response.
- Hold: 3x1 fill at (10,10), hold=1 for 2 cycles after the first plot.
  - Required: sequence (10,10) plot, 2 cycles plot=0 at (11,10), then (11,10), (12,10) plotted.
  - Total 3 plots; done follows.
- Start while busy: a second start 1 cycle into a 2x2 fill, with different colour and coordinates.
  - Required: the original 4 pixels only.
  - A start pulsed during the done cycle is also ignored.
- Reset mid-fill: resetn=0 asynchronously during pixel 2 of a 4x4 fill.
  - Required: all outputs 0 immediately, without waiting for a clock edge.
  - After release, IDLE; a new 1x1 fill at (0,0) plots once and completes normally.
